// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler
// Buffers one pending sample per channel and picks the next channel round-robin.
// Issues exactly one sample, with a one-cycle load strobe, per host SPI frame.
// A frame is complete when chip-select goes low and then high again.
// Sticky per-channel overrun flags record captures that overwrote an unsent sample.
// drop_cnt saturates and counts frames the host never started.
module spi_frame_scheduler #(
    parameter int NCH           = 4,
    parameter int CHW           = 2,
    parameter int DW            = 12,
    parameter int START_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    smp_valid,
    input  logic [NCH*DW-1:0] smp_data,
    input  logic              cs,
    output logic [DW-1:0]     data_out,
    output logic              new_data,
    output logic [CHW-1:0]    ch_id,
    output logic              busy,
    output logic [NCH-1:0]    overrun,
    input  logic              ovr_clr,
    output logic [7:0]        drop_cnt
);

    localparam int TW = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_END   = 2'd2,
        S_GAP        = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cs_meta_q, cs_sync_q;
    logic [DW-1:0]   hold_q [NCH];
    logic [DW-1:0]   hold_d [NCH];
    logic [NCH-1:0]  pending_q, pending_d;
    logic [CHW-1:0]  rr_q, rr_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            new_data_q, new_data_d;
    logic [CHW-1:0]  ch_id_q, ch_id_d;
    logic            busy_q, busy_d;
    logic [NCH-1:0]  overrun_q, overrun_d;
    logic [7:0]      drop_q, drop_d;

    logic            grant_found_s;
    logic [CHW-1:0]  grant_idx_s;
    logic [CHW-1:0]  cand_s;
    logic            grant_s;

    // Round-robin search: first pending channel starting just after the last grant.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = CHW'((int'(rr_q) + k) % NCH);
            if (!grant_found_s && pending_q[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Frame FSM next state, grant outputs, sample buffering and overrun tracking.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        data_out_d = data_out_q;
        new_data_d = 1'b0;
        ch_id_d    = ch_id_q;
        drop_d     = drop_q;
        grant_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && grant_found_s) begin
                    grant_s    = 1'b1;
                    data_out_d = hold_q[grant_idx_s];
                    ch_id_d    = grant_idx_s;
                    new_data_d = 1'b1;
                    rr_d       = grant_idx_s;
                    tmo_d      = '0;
                    state_d    = S_WAIT_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_START: begin
                if (!cs_sync_q) begin
                    state_d = S_WAIT_END;
                end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                    // Host never started the frame: the sample is lost, not re-queued.
                    state_d = S_IDLE;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end else begin
                        drop_d = drop_q;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_END: begin
                if (cs_sync_q) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_WAIT_END;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_s) begin
            pending_d[grant_idx_s] = 1'b0;
        end else begin
            pending_d = pending_d;
        end

        // A new overrun in the same cycle as ovr_clr leaves its flag set.
        overrun_d = ovr_clr ? '0 : overrun_q;

        // Captures are applied after the grant, so a same-cycle grant sends the old value.
        for (int i = 0; i < NCH; i++) begin
            if (smp_valid[i]) begin
                hold_d[i]    = smp_data[i*DW +: DW];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(grant_s && (grant_idx_s == CHW'(i)))) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    overrun_d[i] = overrun_d[i];
                end
            end else begin
                hold_d[i] = hold_d[i];
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, data and cs synchronizer registers; the cs flops reset to the idle level (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
            end
            pending_q  <= '0;
            rr_q       <= '0;
            tmo_q      <= '0;
            data_out_q <= '0;
            new_data_q <= 1'b0;
            ch_id_q    <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= '0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cs_meta_q  <= cs;
            cs_sync_q  <= cs_meta_q;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            tmo_q      <= tmo_d;
            data_out_q <= data_out_d;
            new_data_q <= new_data_d;
            ch_id_q    <= ch_id_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
        end
    end

    assign data_out = data_out_q;
    assign new_data = new_data_q;
    assign ch_id    = ch_id_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Self-checking bench for spi_frame_scheduler with a transaction-level reference model.
module tb_spi_frame_scheduler;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int DW  = 12;
    localparam int T   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [NCH-1:0]    smp_valid = '0;
    logic [NCH*DW-1:0] smp_data = '0;
    logic              cs = 1'b1;
    logic [DW-1:0]     data_out;
    logic              new_data;
    logic [CHW-1:0]    ch_id;
    logic              busy;
    logic [NCH-1:0]    overrun;
    logic              ovr_clr = 1'b0;
    logic [7:0]        drop_cnt;

    // Reference model state
    logic [DW-1:0]  m_hold [NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_ovr;
    int             m_rr;
    int             cyc = 0;
    int             last_strobe = -100;
    int             n_strobe = 0;
    int             n_tests = 0;
    int             n_fail = 0;

    spi_frame_scheduler #(
        .NCH(NCH), .CHW(CHW), .DW(DW), .START_TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .smp_valid(smp_valid), .smp_data(smp_data),
        .cs(cs), .data_out(data_out), .new_data(new_data), .ch_id(ch_id), .busy(busy),
        .overrun(overrun), .ovr_clr(ovr_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick();
        for (int k = 1; k <= NCH; k++) begin
            if (m_pend[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
        end
        return -1;
    endfunction

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        smp_data[ch*DW +: DW] = d;
    endtask

    // One clock: sample outputs after the edge and advance the model with the inputs seen at it.
    task automatic step();
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
        logic              clr;
        logic              r;
        int                g;
        int                e;
        logic [NCH-1:0]    ovr_n;
        v = smp_valid; d = smp_data; clr = ovr_clr; r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            for (int i = 0; i < NCH; i++) m_hold[i] = '0;
            m_pend = '0; m_ovr = '0; m_rr = 0; last_strobe = -100;
        end else begin
            g = -1;
            if (new_data === 1'b1) begin
                n_strobe++;
                e = rr_pick();
                n_tests++;
                if (e < 0) begin
                    n_fail++;
                    $display("FAIL strobe_spurious: new_data=1 at cycle %0d with nothing pending", cyc);
                end else begin
                    n_tests++;
                    if (ch_id !== CHW'(e) || data_out !== m_hold[e]) begin
                        n_fail++;
                        $display("FAIL grant: got ch=%0d data=%h, expected ch=%0d data=%h",
                                 ch_id, data_out, e, m_hold[e]);
                    end
                    m_pend[e] = 1'b0; m_rr = e; g = e;
                end
                n_tests++;
                if (cyc - last_strobe < 4) begin
                    n_fail++;
                    $display("FAIL strobe_spacing: got %0d cycles, required >= 4", cyc - last_strobe);
                end
                last_strobe = cyc;
            end
            ovr_n = clr ? '0 : m_ovr;
            for (int i = 0; i < NCH; i++) begin
                if (v[i]) begin
                    if (m_pend[i]) ovr_n[i] = 1'b1;
                    m_hold[i] = d[i*DW +: DW];
                    m_pend[i] = 1'b1;
                end
            end
            m_ovr = ovr_n;
        end
        n_tests++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun_model: got %b expected %b at cycle %0d", overrun, m_ovr, cyc);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; cs = 1'b1; smp_valid = '0; ovr_clr = 1'b0; en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok, input int maxc);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (new_data === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL strobe_timeout: no new_data within %0d cycles", maxc);
        end
    endtask

    task automatic host_frame(input int lo);
        cs = 1'b0;
        repeat (lo) step();
        cs = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; smp_valid = '1; smp_data = {NCH{12'hFFF}}; cs = 1'b0; ovr_clr = 1'b0;
        step();
        n_tests++;
        if (data_out !== 12'h000 || new_data !== 1'b0 || ch_id !== 2'd0 || busy !== 1'b0 ||
            overrun !== 4'b0000 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: got data=%h nd=%b ch=%0d busy=%b ovr=%b drop=%0d, expected all zero",
                     data_out, new_data, ch_id, busy, overrun, drop_cnt);
        end
        smp_valid = '0; cs = 1'b1; en = 1'b0; rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        en = 1'b1;
        smp_valid = 4'b0100; set_data(2, 12'hA5C);
        step();
        smp_valid = '0;
        step();
        n_tests++;
        if (new_data !== 1'b1 || data_out !== 12'hA5C || ch_id !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got nd=%b data=%h ch=%0d busy=%b, expected 1 a5c 2 1",
                     new_data, data_out, ch_id, busy);
        end
        step();
        n_tests++;
        if (new_data !== 1'b0) begin
            n_fail++;
            $display("FAIL single_strobe_width: got new_data=%b, expected 0", new_data);
        end
        cs = 1'b0;
        repeat (40) step();
        cs = 1'b1;
        repeat (3) step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_hold: got busy=%b 3 cycles after cs rise, expected 1", busy);
        end
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: got busy=%b 4 cycles after cs rise, expected 0", busy);
        end
    endtask

    task automatic test_all4();
        int exp_order [4] = '{1, 2, 3, 0};
        bit ok;
        apply_reset();
        en = 1'b1;
        smp_valid = '1;
        for (int i = 0; i < NCH; i++) set_data(i, 12'h100 + DW'(i));
        step();
        smp_valid = '0;
        n_strobe = 0;
        for (int f = 0; f < 4; f++) begin
            wait_strobe(ok, 20);
            n_tests++;
            if (ch_id !== CHW'(exp_order[f])) begin
                n_fail++;
                $display("FAIL all4_order: frame %0d got ch=%0d expected %0d", f, ch_id, exp_order[f]);
            end
            host_frame(6);
        end
        repeat (10) step();
        n_tests++;
        if (n_strobe != 4 || overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL all4_count: got %0d strobes ovr=%b, expected 4 strobes ovr=0000", n_strobe, overrun);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        apply_reset();
        smp_valid = 4'b0001; set_data(0, 12'h011);
        step();
        set_data(0, 12'h022);
        step();
        smp_valid = '0;
        step();
        n_tests++;
        if (overrun !== 4'b0001) begin
            n_fail++;
            $display("FAIL overrun_set: got %b expected 0001", overrun);
        end
        en = 1'b1;
        wait_strobe(ok, 10);
        n_tests++;
        if (data_out !== 12'h022 || ch_id !== 2'd0) begin
            n_fail++;
            $display("FAIL overrun_data: got data=%h ch=%0d expected 022 ch 0", data_out, ch_id);
        end
        host_frame(5);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        n_tests++;
        if (overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b expected 0000", overrun);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int gap;
        int frames;
        int exp_drop;
        apply_reset();
        smp_valid = 4'b1001; set_data(0, 12'h300); set_data(3, 12'h333);
        step();
        smp_valid = '0; en = 1'b1;
        wait_strobe(ok, 10);
        n_tests++;
        if (ch_id !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_first: got ch=%0d expected 3", ch_id);
        end
        gap = 0;
        for (int i = 0; i < T + 10; i++) begin
            step();
            gap++;
            if (new_data === 1'b1) break;
        end
        n_tests++;
        if (gap != T + 1 || ch_id !== 2'd0 || drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_drop: got gap=%0d ch=%0d drop=%0d, expected gap=%0d ch=0 drop=1",
                     gap, ch_id, drop_cnt, T + 1);
        end
        frames = 2;
        for (int n = 0; n < 299; n++) begin
            smp_valid = '0;
            smp_valid[$urandom_range(NCH - 1, 0)] = 1'b1;
            smp_data = {$urandom, $urandom};
            step();
            smp_valid = '0;
            wait_strobe(ok, T + 5);
            frames++;
            exp_drop = (frames - 1 > 255) ? 255 : frames - 1;
            n_tests++;
            if (drop_cnt !== 8'(exp_drop)) begin
                n_fail++;
                $display("FAIL drop_count: frame %0d got %0d expected %0d", frames, drop_cnt, exp_drop);
            end
        end
        repeat (T + 3) step();
        n_tests++;
        if (drop_cnt !== 8'd255 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_saturate: got drop=%0d busy=%b expected 255 0", drop_cnt, busy);
        end
    endtask

    task automatic test_capture_grant();
        bit ok;
        apply_reset();
        smp_valid = 4'b0010; set_data(1, 12'h0AA);
        step();
        smp_valid = '0;
        step();
        en = 1'b1; smp_valid = 4'b0010; set_data(1, 12'h0BB);
        step();
        smp_valid = '0;
        n_tests++;
        if (new_data !== 1'b1 || data_out !== 12'h0AA || ch_id !== 2'd1 || overrun[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL cap_grant_old: got nd=%b data=%h ch=%0d ovr1=%b expected 1 0aa 1 0",
                     new_data, data_out, ch_id, overrun[1]);
        end
        host_frame(5);
        wait_strobe(ok, 10);
        n_tests++;
        if (data_out !== 12'h0BB || ch_id !== 2'd1 || overrun !== 4'b0000) begin
            n_fail++;
            $display("FAIL cap_grant_new: got data=%h ch=%0d ovr=%b expected 0bb 1 0000",
                     data_out, ch_id, overrun);
        end
        host_frame(5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        en = 1'b1;
        smp_valid = 4'b0100; set_data(2, 12'h222);
        step();
        smp_valid = '0;
        wait_strobe(ok, 10);
        cs = 1'b0;
        repeat (4) step();
        smp_valid = 4'b0011; set_data(0, 12'h0C0); set_data(1, 12'h0C1);
        step();
        smp_valid = '0;
        step();
        rst = 1'b1; cs = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || new_data !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b nd=%b expected 0 0", busy, new_data);
        end
        n_strobe = 0;
        repeat (10) step();
        n_tests++;
        if (n_strobe != 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d strobes expected 0", n_strobe);
        end
        smp_valid = 4'b0011;
        step();
        smp_valid = '0;
        wait_strobe(ok, 10);
        n_tests++;
        if (ch_id !== 2'd1 || data_out !== 12'h0C1) begin
            n_fail++;
            $display("FAIL reset_rr: got ch=%0d data=%h expected 1 0c1", ch_id, data_out);
        end
        host_frame(5);
    endtask

    task automatic test_random();
        int lo_cnt;
        apply_reset();
        n_strobe = 0;
        lo_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) smp_valid[i] = ($urandom_range(7, 0) == 0);
            smp_data = {$urandom, $urandom};
            en = ($urandom_range(7, 0) != 0);
            ovr_clr = ($urandom_range(19, 0) == 0);
            if (cs && busy && $urandom_range(2, 0) == 0) begin
                cs = 1'b0;
                lo_cnt = $urandom_range(20, 2);
            end else if (!cs) begin
                lo_cnt--;
                if (lo_cnt <= 0) cs = 1'b1;
            end
            step();
        end
        smp_valid = '0; ovr_clr = 1'b0; en = 1'b0; cs = 1'b1;
        repeat (T + 6) step();
        n_tests++;
        if (n_strobe < 20) begin
            n_fail++;
            $display("FAIL random_activity: got %0d strobes, expected at least 20", n_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_overrun();
        test_timeout();
        test_capture_grant();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
